stream_arb_mux: RTL and testbench

Parametrised N-bit, CH-channel registered stream multiplexer, the successor to our two-input combinational selector. It replaces the external select line with internal arbitration (fixed-priority or round-robin) and valid/ready handshakes. A packet, terminated by `last`, is never interleaved with another channel. It sits on datapath merge points where several producers share one consumer and one registered output stage is acceptable.

---
 rtl/stream_arb_mux.sv | 111 +++++++++++
 tb/tb_stream_arb_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: CH-channel packet-aware arbiter (fixed priority or round-robin) feeding one registered output stage.
// Latency: a beat accepted in cycle t is presented on out_* in cycle t+1; full rate while out_ready stays high.
// Backpressure: out_valid && !out_ready freezes out_* and drops every in_ready; a granted packet keeps its lock.
module stream_arb_mux #(
    parameter int N    = 5,
    parameter int CH   = 4,
    parameter int MODE = 1,
    localparam int SW  = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH-1:0]   in_last,
    output logic [CH-1:0]   in_ready,
    output logic [N-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_sel,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] lock_ch;
    logic [SW-1:0] base;
    logic [SW-1:0] pick;
    logic          pick_vld;
    logic [SW-1:0] gnt;
    logic          gnt_vld;
    logic          ld;
    logic          xfer;
    logic          sel_last;
    logic [N-1:0]  sel_data;

    // Channel visited k steps after base, wrapping CH-1 -> 0.
    function automatic logic [SW-1:0] scan_idx(input logic [SW-1:0] b, input int k);
        int c;
        c = int'(b) + k;
        if (c >= CH) c = c - CH;
        return SW'(c);
    endfunction

    // Fixed priority is a round-robin scan that always starts at channel 0.
    assign base = (MODE == 0) ? '0 : ptr;

    // Free-channel pick: first valid channel scanning upward from base.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (in_valid[scan_idx(base, k)]) begin
                pick_vld = 1'b1;
                pick     = scan_idx(base, k);
            end
        end
    end

    // While a packet is open the locked channel owns the grant, valid or not.
    assign gnt      = (state == LOCK) ? lock_ch : pick;
    assign gnt_vld  = (state == LOCK) | pick_vld;
    assign ld       = ~out_valid | out_ready;
    assign sel_last = in_last[gnt];
    assign sel_data = in_data[int'(gnt) * N +: N];
    assign xfer     = |(in_valid & in_ready);

    // One-hot accept towards the granted channel whenever the output stage can load.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            if (!rst && ld && gnt_vld && (gnt == SW'(i))) in_ready[i] = 1'b1;
        end
    end

    // Arbiter state: packet lock, locked channel and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            if (state == IDLE && !sel_last) begin
                state   <= LOCK;
                lock_ch <= gnt;
            end else if (state == LOCK && sel_last) begin
                state <= IDLE;
            end
            if (sel_last) ptr <= (gnt == SW'(CH - 1)) ? '0 : gnt + 1'b1;
        end
    end

    // Output stage: load on accept, go empty on an idle load slot, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (ld) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_sel  <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: random producers against a queue-level reference model, plus directed scenarios.
// Latency: checks in_ready in the accept cycle and out_* one cycle after.
// Backpressure: random out_ready; producers hold a beat until it is accepted.
`timescale 1ns/1ps
module tb_stream_arb_mux;
    localparam int N  = 5;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_last;
    logic [CH-1:0]   in_ready;
    logic [N-1:0]    out_data;
    logic            out_last;
    logic [SW-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready;

    logic [CH*N-1:0] fp_in_data;
    logic [CH-1:0]   fp_in_valid;
    logic [CH-1:0]   fp_in_last;
    logic [CH-1:0]   fp_in_ready;
    logic [N-1:0]    fp_out_data;
    logic            fp_out_last;
    logic [SW-1:0]   fp_out_sel;
    logic            fp_out_valid;
    logic            fp_out_ready;

    int n_vec = 0;
    int n_err = 0;

    // reference model state (post-edge view)
    int           m_lock;
    int           m_ptr;
    bit           m_valid;
    logic [N-1:0] m_data;
    bit           m_last;
    int           m_sel;

    // producers
    bit           p_vld [CH];
    logic [N-1:0] p_dat [CH];
    bit           p_lst [CH];
    int           p_rem [CH];
    bit           ch_en [CH];
    int           pkt_len [CH];
    int           vld_pct;
    int           rdy_pct;
    int           sel_log [$];

    // fixed-priority directed table: valid, last, expected in_ready
    logic [CH-1:0] fp_v [0:9] = '{4'hF, 4'hF, 4'hF, 4'hA, 4'h8, 4'h4, 4'h5, 4'h5, 4'h1, 4'h0};
    logic [CH-1:0] fp_l [0:9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h4, 4'hF, 4'h0};
    logic [CH-1:0] fp_r [0:9] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h8, 4'h4, 4'h4, 4'h4, 4'h1, 4'h0};

    stream_arb_mux #(.N(N), .CH(CH), .MODE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_arb_mux #(.N(N), .CH(CH), .MODE(0)) dut_fp (
        .clk       (clk),
        .rst       (rst),
        .in_data   (fp_in_data),
        .in_valid  (fp_in_valid),
        .in_last   (fp_in_last),
        .in_ready  (fp_in_ready),
        .out_data  (fp_out_data),
        .out_last  (fp_out_last),
        .out_sel   (fp_out_sel),
        .out_valid (fp_out_valid),
        .out_ready (fp_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic config_src(input logic [CH-1:0] en, input int vld, input int rdy, input int len);
        for (int i = 0; i < CH; i++) begin
            ch_en[i]   = en[i];
            pkt_len[i] = len;
        end
        vld_pct = vld;
        rdy_pct = rdy;
    endtask

    // Present producer beats and a random out_ready.
    task automatic drive();
        for (int i = 0; i < CH; i++) begin
            if (!p_vld[i] && ch_en[i] && ($urandom_range(99) < vld_pct)) begin
                if (p_rem[i] == 0) p_rem[i] = (pkt_len[i] != 0) ? pkt_len[i] : int'($urandom_range(4, 1));
                p_dat[i] = N'($urandom);
                p_lst[i] = (p_rem[i] == 1);
                p_vld[i] = 1'b1;
            end
            in_valid[i]       = p_vld[i];
            in_data[i*N +: N] = p_vld[i] ? p_dat[i] : N'($urandom);
            in_last[i]        = p_vld[i] ? p_lst[i] : 1'($urandom);
        end
        out_ready = ($urandom_range(99) < rdy_pct);
    endtask

    // Compare DUT against the model, then advance the model across the coming edge.
    task automatic evaluate();
        int            g;
        bit            ld;
        bit            xfer;
        logic [CH-1:0] exp_rdy;
        ld = !m_valid || out_ready;
        g  = m_lock;
        if (g < 0) begin
            for (int k = 0; k < CH; k++) begin
                if (g < 0 && in_valid[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
            end
        end
        exp_rdy = (ld && g >= 0) ? CH'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_last", 32'(out_last), 32'(m_last));
            chk("out_sel", 32'(out_sel), 32'(m_sel));
        end
        if (out_valid && out_ready) sel_log.push_back(int'(out_sel));
        xfer = ld && (g >= 0) && in_valid[g];
        if (ld) begin
            m_valid = xfer;
            if (xfer) begin
                m_data = p_dat[g];
                m_last = p_lst[g];
                m_sel  = g;
            end
        end
        if (xfer) begin
            p_vld[g] = 1'b0;
            p_rem[g]--;
            if (p_lst[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % CH;
            end else begin
                m_lock = g;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        evaluate();
    endtask

    // Assert reset mid-cycle with every channel requesting, check the immediate effect, release.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst         = 1'b1;
        in_valid    = '1;
        fp_in_valid = '1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fp_in_ready", 32'(fp_in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        in_valid     = '0;
        fp_in_valid  = '0;
        out_ready    = 1'b0;
        fp_out_ready = 1'b0;
        m_lock  = -1;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_sel   = 0;
        for (int i = 0; i < CH; i++) begin
            p_vld[i] = 1'b0;
            p_dat[i] = '0;
            p_lst[i] = 1'b0;
            p_rem[i] = 0;
        end
        sel_log.delete();
    endtask

    task automatic chk_log(input string tag, input int idx, input int exp);
        chk(tag, (idx < sel_log.size()) ? 32'(sel_log[idx]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    initial begin
        int           prev_sel;
        logic [CH-1:0] prev_rdy;
        logic [N-1:0] prev_dat;
        int           held_sel;
        logic [N-1:0] held_dat;

        rst          = 1'b1;
        in_data      = '0;
        in_valid     = '0;
        in_last      = '0;
        out_ready    = 1'b0;
        fp_in_data   = '0;
        fp_in_valid  = '0;
        fp_in_last   = '0;
        fp_out_ready = 1'b0;
        config_src('0, 0, 0, 0);
        repeat (2) @(posedge clk);
        do_reset();

        // fixed priority: lowest index wins, packet lock still honoured
        prev_rdy = '0;
        prev_sel = 0;
        prev_dat = '0;
        for (int r = 0; r < 10; r++) begin
            @(posedge clk);
            #1;
            fp_out_ready = 1'b1;
            fp_in_valid  = fp_v[r];
            fp_in_last   = fp_l[r];
            fp_in_data   = (CH*N)'($urandom);
            @(negedge clk);
            chk("fp_in_ready", 32'(fp_in_ready), 32'(fp_r[r]));
            chk("fp_out_valid", 32'(fp_out_valid), 32'(prev_rdy != 0));
            if (prev_rdy != 0) begin
                chk("fp_out_sel", 32'(fp_out_sel), 32'(prev_sel));
                chk("fp_out_data", 32'(fp_out_data), 32'(prev_dat));
            end
            prev_rdy = fp_r[r];
            for (int i = 0; i < CH; i++) begin
                if (fp_r[r][i]) begin
                    prev_sel = i;
                    prev_dat = fp_in_data[i*N +: N];
                end
            end
        end

        // single beat from ch2
        do_reset();
        config_src('0, 0, 100, 1);
        p_vld[2] = 1'b1;
        p_dat[2] = 5'h15;
        p_lst[2] = 1'b1;
        p_rem[2] = 1;
        step();
        step();
        chk("single_data", 32'(out_data), 32'h15);
        chk("single_sel", 32'(out_sel), 32'd2);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_last", 32'(out_last), 32'd1);

        // round-robin over four always-valid channels
        do_reset();
        config_src(4'hF, 100, 100, 1);
        repeat (9) step();
        chk("rr_count", 32'(sel_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk_log("rr_sel", k, k % CH);

        // 3-beat packet on ch1 locks out ch0
        do_reset();
        config_src(4'b0010, 100, 100, 0);
        pkt_len[1] = 3;
        step();
        ch_en[0]   = 1'b1;
        pkt_len[0] = 1;
        step();
        chk("lock_rdy0_b2", 32'(in_ready[0]), 32'd0);
        step();
        chk("lock_rdy0_b3", 32'(in_ready[0]), 32'd0);
        step();
        chk("lock_rdy0_free", 32'(in_ready[0]), 32'd1);
        step();
        chk_log("lock_sel0", 0, 1);
        chk_log("lock_sel1", 1, 1);
        chk_log("lock_sel2", 2, 1);
        chk_log("lock_sel3", 3, 0);

        // backpressure hold and release
        do_reset();
        config_src(4'hF, 100, 100, 1);
        step();
        step();
        rdy_pct = 0;
        step();
        held_sel = int'(out_sel);
        held_dat = out_data;
        repeat (3) begin
            step();
            chk("bp_sel", 32'(out_sel), 32'(held_sel));
            chk("bp_data", 32'(out_data), 32'(held_dat));
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        rdy_pct = 100;
        step();
        step();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_sel", 32'(out_sel), 32'((held_sel + 1) % CH));

        // pointer wrap: ptr=3 with ch0 and ch3 requesting
        do_reset();
        config_src(4'b0100, 100, 100, 1);
        step();
        config_src(4'b1001, 100, 100, 1);
        repeat (3) step();
        chk_log("wrap_sel0", 0, 2);
        chk_log("wrap_sel1", 1, 3);
        chk_log("wrap_sel2", 2, 0);

        // random traffic, reset dropped mid-stream, then a high-load run
        do_reset();
        config_src(4'hF, 60, 70, 0);
        repeat (3000) step();
        do_reset();
        config_src(4'hF, 60, 70, 0);
        repeat (1500) step();
        config_src(4'hF, 100, 90, 0);
        repeat (1000) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
